exu_lsu_bridge: RTL
===================

Name: exu_lsu_bridge

Overview:
- Sits directly downstream of the execute stage's memory port.
- Accepts the execute stage's req/gnt/rvalid load-store handshake and converts it into a split command/response valid-ready bus toward the data RAM and peripheral interconnect.
- Supports one outstanding access at a time.
- Adds address-range decode errors, a response timeout, and drops late responses that belong to timed-out accesses.

Parameters:
ADDR_BASE, 32'h1000_0000, lowest decodable byte address
ADDR_SIZE, 32'h1000_0000, size of the decodable window in bytes
TIMEOUT_CYCLES, 255, cycles allowed from command issue to response; 0 disables the timeout
DROP_CNT_W, 4, width of the stale-response counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_req_i  in  1  access request from execute stage
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  32  byte address
mem_wdata_i  in  32  store data
mem_be_i  in  4  byte enables
mem_gnt_o  out  1  request accepted this cycle
mem_rvalid_o  out  1  one-cycle completion pulse; sent for loads and stores
mem_rdata_o  out  32  load data, valid with mem_rvalid_o
mem_err_o  out  1  access error, valid with mem_rvalid_o
cmd_valid_o  out  1  bus command valid
cmd_ready_i  in  1  bus command ready
cmd_addr_o  out  32  command address
cmd_write_o  out  1  command is a write
cmd_wdata_o  out  32  write data
cmd_wmask_o  out  4  write byte mask
rsp_valid_i  in  1  bus response valid
rsp_ready_o  out  1  bus response ready
rsp_rdata_i  in  32  response data
rsp_err_i  in  1  bus error
busy_o  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, rst=1):
  - state = IDLE; timer = 0; drop_cnt = 0.
  - All outputs are 0, including the cmd_* registers, mem_rdata_o and mem_err_o.
  - A reset during any state abandons the access with no rvalid pulse.
- States: IDLE, CMD, RSP, ERR.
- Acceptance (IDLE):
  - mem_gnt_o = mem_req_i & (state==IDLE) & (drop_cnt != all-ones). It is combinational.
  - On gnt: latch addr, we, wdata and be into the cmd_* registers.
  - If ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE (compared as unsigned 33-bit, so wrap does not alias), go to CMD. Otherwise go to ERR.
- CMD:
  - cmd_valid_o = 1; the cmd_* registers hold steady until the cycle where cmd_valid_o & cmd_ready_i.
  - On handshake, go to RSP.
- RSP:
  - rsp_ready_o = 1.
  - On rsp_valid_i with drop_cnt==0:
    - Register mem_rdata_o = (write ? 0 : rsp_rdata_i) and mem_err_o = rsp_err_i.
    - mem_rvalid_o = 1 next cycle; go to IDLE.
- ERR:
  - Takes one cycle: mem_rvalid_o = 1, mem_err_o = 1, mem_rdata_o = 0 in the following cycle.
  - Then go to IDLE. No bus command is issued.
- mem_rvalid_o lasts one cycle. mem_rdata_o and mem_err_o hold until the next completion.
- Minimum latency is gnt at T, cmd handshake at T+1, response at T+2, rvalid at T+3.
- A new gnt may occur in the same cycle mem_rvalid_o is high.
- Timer:
  - Cleared on gnt; increments every cycle in CMD or RSP; saturates.
  - When timer == TIMEOUT_CYCLES and TIMEOUT_CYCLES != 0, the access times out: go to IDLE, pulse mem_rvalid_o next cycle with mem_err_o = 1 and mem_rdata_o = 0.
  - Timeout in CMD: cmd_valid_o deasserts with no handshake; drop_cnt is unchanged.
  - Timeout in RSP: drop_cnt += 1.
  - A response (or cmd handshake) arriving in the same cycle as the timeout wins, and no timeout occurs.
- Stale responses:
  - rsp_ready_o = (state==RSP) | (drop_cnt != 0).
  - Any rsp handshake while drop_cnt != 0 decrements drop_cnt and is discarded, even in RSP.
  - A timeout and a discard in the same cycle leave drop_cnt unchanged.
  - When drop_cnt is all-ones, new requests are not granted.
- busy_o = (state != IDLE).

Test Plan:
- Load, zero-wait bus:
  - Stimulus: req at T with addr 0x1000_0040, we=0; cmd_ready=1; rsp_valid at T+2 with rdata 0xDEAD_BEEF.
  - Response: gnt at T, cmd_valid T+1, rvalid T+3 with rdata 0xDEAD_BEEF, err 0.
- Store with backpressure:
  - Stimulus: sw to 0x1000_0004, wdata 0x1234_5678, be 4'hF; cmd_ready low for 3 cycles.
  - Response: cmd fields stable for 4 cycles; rvalid with rdata 0, err 0.
- Decode error:
  - Stimulus: req with addr 0x0000_0010.
  - Response: gnt, no cmd_valid ever, rvalid next-next cycle with err=1, rdata=0.
- Timeout then late response:
  - Stimulus: TIMEOUT_CYCLES=8; response withheld; then rsp_valid with 0xAAAA_AAAA after the timeout.
  - Response: err rvalid from the timeout; drop_cnt=1; late response consumed and discarded (no rvalid); next load completes normally with its own data.
- Response coincident with timeout:
  - Stimulus: TIMEOUT_CYCLES=4; rsp_valid exactly at timer==4.
  - Response: normal completion with err=0; drop_cnt stays 0.
- Reset mid-access:
  - Stimulus: assert rst while in RSP.
  - Response: all outputs 0 immediately (asynchronously); no rvalid; state IDLE after release.

Source files
------------

// File: rtl/exu_lsu_bridge_if.sv
// Execute-stage req/gnt/rvalid port plus split cmd/rsp bus toward memory.
// slave = bridge view, master = surrounding environment view.
interface exu_lsu_bridge_if;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_be_i;
   logic        mem_gnt_o;
   logic        mem_rvalid_o;
   logic [31:0] mem_rdata_o;
   logic        mem_err_o;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic [31:0] cmd_addr_o;
   logic        cmd_write_o;
   logic [31:0] cmd_wdata_o;
   logic [3:0]  cmd_wmask_o;
   logic        rsp_valid_i;
   logic        rsp_ready_o;
   logic [31:0] rsp_rdata_i;
   logic        rsp_err_i;
   logic        busy_o;

   modport slave (
      input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
      output mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_err_o,
      output cmd_valid_o, cmd_addr_o, cmd_write_o, cmd_wdata_o, cmd_wmask_o,
      input  cmd_ready_i,
      input  rsp_valid_i, rsp_rdata_i, rsp_err_i,
      output rsp_ready_o, busy_o
   );

   modport master (
      output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
      input  mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_err_o,
      input  cmd_valid_o, cmd_addr_o, cmd_write_o, cmd_wdata_o, cmd_wmask_o,
      output cmd_ready_i,
      output rsp_valid_i, rsp_rdata_i, rsp_err_i,
      input  rsp_ready_o, busy_o
   );
endinterface

// File: rtl/exu_lsu_bridge.sv
// Converts req/gnt/rvalid into one-outstanding cmd/rsp valid-ready; best case gnt->rvalid is 3 cycles.
// Backpressure: cmd held until cmd_ready_i or timeout; requests refused while busy or stale-counter full.
module exu_lsu_bridge #(
   parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
   parameter logic [31:0] ADDR_SIZE      = 32'h1000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned DROP_CNT_W     = 4
) (
   input logic             clk,
   input logic             rst,
   exu_lsu_bridge_if.slave bus
);

   localparam int unsigned     TMR_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
   localparam bit              TMO_EN    = (TIMEOUT_CYCLES != 0);
   // 33-bit bounds so a window ending at 4 GiB does not wrap to zero.
   localparam logic [32:0]     RANGE_LO  = {1'b0, ADDR_BASE};
   localparam logic [32:0]     RANGE_HI  = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

   typedef enum logic [1:0] {IDLE, CMD, RSP, ERR} state_t;

   state_t                state;
   logic [TMR_W-1:0]      timer;
   logic [DROP_CNT_W-1:0] drop_cnt;
   logic [DROP_CNT_W-1:0] drop_nxt;
   logic [31:0]           cmd_addr_q;
   logic                  cmd_write_q;
   logic [31:0]           cmd_wdata_q;
   logic [3:0]            cmd_wmask_q;
   logic                  rvalid_q;
   logic [31:0]           rdata_q;
   logic                  err_q;

   logic gnt;
   logic in_range;
   logic drop_any;
   logic drop_full;
   logic rsp_hs;
   logic discard;
   logic rsp_take;
   logic tmo_hit;
   logic tmo_cmd;
   logic tmo_rsp;

   assign drop_any  = |drop_cnt;
   assign drop_full = &drop_cnt;
   assign gnt       = bus.mem_req_i & (state == IDLE) & ~drop_full & ~rst;
   assign in_range  = ({1'b0, bus.mem_addr_i} >= RANGE_LO) && ({1'b0, bus.mem_addr_i} < RANGE_HI);

   assign rsp_hs   = bus.rsp_valid_i & bus.rsp_ready_o;
   assign discard  = rsp_hs & drop_any;
   assign rsp_take = rsp_hs & (state == RSP) & ~drop_any;

   // A handshake landing on the deadline cycle beats the timeout.
   assign tmo_hit = TMO_EN && (timer == TMR_LIMIT) && ((state == CMD) || (state == RSP));
   assign tmo_cmd = tmo_hit & (state == CMD) & ~bus.cmd_ready_i;
   assign tmo_rsp = tmo_hit & (state == RSP) & ~rsp_take;

   always_comb begin
      drop_nxt = drop_cnt;
      if (tmo_rsp && !discard)
         drop_nxt = drop_cnt + 1'b1;
      else if (discard && !tmo_rsp)
         drop_nxt = drop_cnt - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         drop_cnt    <= '0;
         cmd_addr_q  <= '0;
         cmd_write_q <= 1'b0;
         cmd_wdata_q <= '0;
         cmd_wmask_q <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         drop_cnt <= drop_nxt;
         if (((state == CMD) || (state == RSP)) && (timer != '1))
            timer <= timer + 1'b1;

         case (state)
            IDLE: begin
               if (gnt) begin
                  cmd_addr_q  <= bus.mem_addr_i;
                  cmd_write_q <= bus.mem_we_i;
                  cmd_wdata_q <= bus.mem_wdata_i;
                  cmd_wmask_q <= bus.mem_be_i;
                  timer       <= '0;
                  state       <= in_range ? CMD : ERR;
               end
            end
            CMD: begin
               if (bus.cmd_ready_i) begin
                  state <= RSP;
               end else if (tmo_cmd) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= '0;
                  err_q    <= 1'b1;
                  state    <= IDLE;
               end
            end
            RSP: begin
               if (rsp_take) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= cmd_write_q ? 32'h0 : bus.rsp_rdata_i;
                  err_q    <= bus.rsp_err_i;
                  state    <= IDLE;
               end else if (tmo_rsp) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= '0;
                  err_q    <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               rvalid_q <= 1'b1;
               rdata_q  <= '0;
               err_q    <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_gnt_o    = gnt;
   assign bus.mem_rvalid_o = rvalid_q;
   assign bus.mem_rdata_o  = rdata_q;
   assign bus.mem_err_o    = err_q;
   assign bus.cmd_valid_o  = (state == CMD);
   assign bus.cmd_addr_o   = cmd_addr_q;
   assign bus.cmd_write_o  = cmd_write_q;
   assign bus.cmd_wdata_o  = cmd_wdata_q;
   assign bus.cmd_wmask_o  = cmd_wmask_q;
   assign bus.rsp_ready_o  = (state == RSP) | drop_any;
   assign bus.busy_o       = (state != IDLE);

endmodule
